// File: rtl/oled_text_fmt.sv
// Formats four 32-bit debug words into a 4x16 ASCII screen image for the OLED controller.
// Hex digits build up in a shadow buffer one nibble per cycle and reach char_data together.
module oled_text_fmt #(
    parameter logic [31:0] LABEL0 = "PC  ",
    parameter logic [31:0] LABEL1 = "INST",
    parameter logic [31:0] LABEL2 = "RS  ",
    parameter logic [31:0] LABEL3 = "RT  ",
    parameter bit          AUTO   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] vals,
    input  logic         refresh,
    input  logic         print_fin,
    output logic [511:0] char_data,
    output logic         busy,
    output logic         upd_done,
    output logic [1:0]   state_dbg
);

    // Handshake: a request is sampled only in IDLE; while busy it is dropped, never queued.
    typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, COMMIT = 2'd2} state_t;

    localparam logic [127:0] LABELS = {LABEL0, LABEL1, LABEL2, LABEL3};

    state_t       state, state_nx;
    logic [127:0] vals_q;
    logic [4:0]   nib;
    logic [7:0]   shadow [32];
    logic [7:0]   hex_q  [32];
    logic         print_fin_d;
    logic         pf_armed;
    logic         req;
    logic [3:0]   cur_nib;

    function automatic logic [7:0] to_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // pf_armed makes a print_fin held high across reset wait for a low sample first.
    assign req     = refresh | (AUTO & print_fin & ~print_fin_d & pf_armed);
    assign cur_nib = vals_q[(7'd124 - {nib, 2'b00}) +: 4];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = CONV;
            CONV:    if (nib == 5'd31) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        state_dbg = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vals_q      <= '0;
            nib         <= '0;
            print_fin_d <= 1'b0;
            pf_armed    <= 1'b0;
            upd_done    <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                shadow[i] <= 8'h20;
                hex_q[i]  <= 8'h20;
            end
        end else begin
            print_fin_d <= print_fin;
            pf_armed    <= pf_armed | ~print_fin;
            upd_done    <= (state == COMMIT);
            case (state)
                IDLE: begin
                    if (req) begin
                        vals_q <= vals;
                        nib    <= '0;
                    end
                end
                CONV: begin
                    shadow[nib] <= to_hex(cur_nib);
                    nib         <= nib + 5'd1;
                end
                COMMIT: begin
                    for (int i = 0; i < 32; i++) hex_q[i] <= shadow[i];
                end
                default: ;
            endcase
        end
    end

    // Labels, colon and spaces are wired constants; only the hex fields are registered.
    always_comb begin
        char_data = '0;
        for (int l = 0; l < 4; l++) begin
            for (int c = 0; c < 4; c++)
                char_data[511 - 8*(16*l + c) -: 8] = LABELS[127 - 32*l - 8*c -: 8];
            char_data[511 - 8*(16*l + 4) -: 8] = 8'h3A;
            for (int c = 5; c < 8; c++)
                char_data[511 - 8*(16*l + c) -: 8] = 8'h20;
            for (int d = 0; d < 8; d++)
                char_data[511 - 8*(16*l + 8 + d) -: 8] = hex_q[8*l + d];
        end
    end

endmodule

// File: tb/tb_oled_text_fmt.sv
// Directed bench for oled_text_fmt: vector table of full passes plus hand-written timing sequences.
module tb_oled_text_fmt;

    logic         clk;
    logic         rst;
    logic [127:0] vals;
    logic         refresh;
    logic         print_fin;
    logic [511:0] char_data;
    logic         busy;
    logic         upd_done;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] vals;
        logic [63:0]  e0, e1, e2, e3;
    } vec_t;

    vec_t vecs [3];

    oled_text_fmt dut (
        .clk       (clk),
        .rst       (rst),
        .vals      (vals),
        .refresh   (refresh),
        .print_fin (print_fin),
        .char_data (char_data),
        .busy      (busy),
        .upd_done  (upd_done),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] hexf(input int l);
        return char_data[447 - 128*l -: 64];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request at edge k, then follow busy/upd_done until commit and check the image.
    task automatic do_pass(input logic [127:0] v, input logic [63:0] e0, input logic [63:0] e1,
                           input logic [63:0] e2, input logic [63:0] e3, input string tag);
        int lat;
        bit busy_ok;
        vals    = v;
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        check({tag, "_busy_k"}, busy, 1'b1);
        lat = 0;
        busy_ok = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (upd_done) begin
                lat = j;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, lat, 33);
        check({tag, "_busy_hold"}, busy_ok, 1'b1);
        check({tag, "_busy_commit"}, busy, 1'b0);
        check({tag, "_line0"}, hexf(0), e0);
        check({tag, "_line1"}, hexf(1), e1);
        check({tag, "_line2"}, hexf(2), e2);
        check({tag, "_line3"}, hexf(3), e3);
        tick();
        check({tag, "_upd_one_cycle"}, upd_done, 1'b0);
        check({tag, "_idle_after"}, busy, 1'b0);
    endtask

    initial begin
        logic [511:0] snap;
        logic [127:0] exp_line;
        bit           stable;
        bit           seen_upd;
        bit           seen_busy;
        int           lat;
        int           gap;

        vecs[0] = '{vals: {32'h0040_001C, 32'h8C22_0004, 32'hDEAD_BEEF, 32'h0000_0000},
                    e0: "0040001C", e1: "8C220004", e2: "DEADBEEF", e3: "00000000"};
        vecs[1] = '{vals: {32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 32'hA5A5_5A5A},
                    e0: "12345678", e1: "9ABCDEF0", e2: "FFFFFFFF", e3: "A5A55A5A"};
        vecs[2] = '{vals: {32'h0F0F_0F0F, 32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFE},
                    e0: "0F0F0F0F", e1: "00000001", e2: "80000000", e3: "7FFFFFFE"};

        rst = 1'b1; refresh = 1'b0; print_fin = 1'b0; vals = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_line = {"PC  :   ", "        "};
        check("rst_line0", char_data[511:384], exp_line);
        exp_line = {"INST:   ", "        "};
        check("rst_line1", char_data[383:256], exp_line);
        exp_line = {"RT  :   ", "        "};
        check("rst_line3", char_data[127:0], exp_line);
        check("rst_busy", busy, 1'b0);
        check("rst_upd", upd_done, 1'b0);
        check("rst_state", state_dbg, 2'd0);

        for (int i = 0; i < 3; i++)
            do_pass(vecs[i].vals, vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3, $sformatf("vec%0d", i));
        exp_line = {"RS  :   ", "80000000"};
        check("static_line2", char_data[255:128], exp_line);

        // Atomicity, snapshot, and an ignored request mid-pass.
        snap    = char_data;
        vals    = vecs[0].vals;
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        stable  = 1'b1;
        lat     = 0;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (upd_done) begin
                lat = j;
                break;
            end
            if (char_data !== snap) stable = 1'b0;
            if (j == 4) vals = {128{1'b1}};
            if (j == 9) begin
                vals    = vecs[1].vals;
                refresh = 1'b1;
            end
            if (j == 10) refresh = 1'b0;
        end
        check("atom_stable", stable, 1'b1);
        check("atom_latency", lat, 33);
        check("atom_line0", hexf(0), vecs[0].e0);
        check("atom_line2", hexf(2), vecs[0].e2);
        tick();
        check("ignored_req_idle", busy, 1'b0);
        seen_busy = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            if (busy) seen_busy = 1'b1;
        end
        check("ignored_req_no_pass", seen_busy, 1'b0);

        // AUTO re-arm from a print_fin rising edge; held high must not retrigger.
        vals      = vecs[1].vals;
        print_fin = 1'b1;
        tick();
        check("auto_busy_m", busy, 1'b1);
        lat = 0;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (upd_done) begin
                lat = j;
                break;
            end
        end
        check("auto_latency", lat, 33);
        check("auto_line1", hexf(1), vecs[1].e1);
        seen_busy = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (busy) seen_busy = 1'b1;
        end
        check("auto_no_retrigger", seen_busy, 1'b0);
        print_fin = 1'b0;
        tick();

        // refresh held high: back-to-back passes.
        vals    = vecs[2].vals;
        refresh = 1'b1;
        lat = 0;
        for (int j = 1; j <= 80; j++) begin
            tick();
            if (upd_done) begin
                lat = j;
                break;
            end
        end
        gap = 0;
        for (int j = 1; j <= 80; j++) begin
            tick();
            if (upd_done) begin
                gap = j;
                break;
            end
        end
        refresh = 1'b0;
        check("b2b_first_seen", (lat != 0), 1'b1);
        check("b2b_period", gap, 34);
        tick();
        tick();
        check("b2b_idle", busy, 1'b0);

        // Reset mid-pass with print_fin held high across the reset release.
        vals    = vecs[0].vals;
        refresh = 1'b1;
        tick();
        refresh  = 1'b0;
        seen_upd = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            if (j == 15) begin
                rst       = 1'b1;
                print_fin = 1'b1;
            end
            tick();
            if (upd_done) seen_upd = 1'b1;
        end
        check("midrst_no_upd", seen_upd, 1'b0);
        for (int l = 0; l < 4; l++)
            check($sformatf("midrst_line%0d", l), hexf(l), {8{8'h20}});
        check("midrst_busy", busy, 1'b0);
        check("midrst_state", state_dbg, 2'd0);
        rst = 1'b0;
        seen_upd  = 1'b0;
        seen_busy = 1'b0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (upd_done) seen_upd = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        check("pf_high_at_release_upd", seen_upd, 1'b0);
        check("pf_high_at_release_busy", seen_busy, 1'b0);
        print_fin = 1'b0;
        tick();
        print_fin = 1'b1;
        tick();
        check("pf_rearm_busy", busy, 1'b1);
        lat = 0;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (upd_done) begin
                lat = j;
                break;
            end
        end
        check("pf_rearm_latency", lat, 33);
        check("pf_rearm_line3", hexf(3), vecs[0].e3);
        print_fin = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oled_text_fmt.md
# oled_text_fmt

Formats four 32-bit debug words (PC, instruction, operands) into the 64-character, 4-line × 16-column ASCII screen image consumed by the OLED controller's `char_data` input. It snapshots the words on a refresh request and converts them to upper-case hex one nibble per cycle into a shadow buffer. It then commits the whole image atomically, so the display never sees a half-updated screen. It sits directly upstream of the OLED controller and can re-arm itself from the controller's `print_fin`.

## Interface
Parameters:
- `LABEL0`, default `"PC  "`: 32-bit, 4 ASCII chars, label of line 0.
- `LABEL1`, default `"INST"`: label of line 1.
- `LABEL2`, default `"RS  "`: label of line 2.
- `LABEL3`, default `"RT  "`: label of line 3.
- `AUTO`, default `1`: 1 = a rising edge of `print_fin` also requests a refresh.

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `vals`, input, 128: `vals[127:96]` line 0, `[95:64]` line 1, `[63:32]` line 2, `[31:0]` line 3.
- `refresh`, input, 1: request a new snapshot/format pass (level sampled in IDLE).
- `print_fin`, input, 1: from the OLED controller; rising edge is a refresh request when `AUTO=1`.
- `char_data`, output, 512: screen image; char index i (0 = top-left, row-major) at `[511-8i : 504-8i]`.
- `busy`, output, 1: high while a pass is in progress.
- `upd_done`, output, 1: one-cycle pulse when `char_data` has just been committed.

## Operation
- Line L occupies chars 16L..16L+15:
  - 16L+0..3: label (MSB byte of LABELn first).
  - 16L+4: `':'` (0x3A).
  - 16L+5..7: 0x20.
  - 16L+8..15: 8 hex digits, MSB nibble first.
- Hex encoding: nibble 0–9 maps to 0x30+n; 10–15 maps to 0x41+(n−10), upper case.
- Registered `vals_q` (128 b), shadow buffer (hex fields only, 32 bytes), 5-bit nibble counter `nib`, FSM `IDLE`, `CONV`, `COMMIT`.
- `req` = `refresh` | (`AUTO` & `print_fin` & ~`print_fin_d`), where `print_fin_d` is `print_fin` registered.
- IDLE: if `req`, latch `vals` into `vals_q`, `nib` ← 0, go to CONV. Otherwise stay.
- CONV: convert nibble `nib` (line `nib[4:3]`, digit `nib[2:0]`, digit 0 = bits [31:28]) into the shadow buffer, `nib` ← `nib`+1. After `nib`=31 is written, go to COMMIT.
- COMMIT: copy the shadow hex fields into `char_data`, pulse `upd_done`, go to IDLE.
- Static chars (labels, `':'`, spaces) are constant in `char_data` at all times, including reset.
- Requests in CONV/COMMIT are ignored and not queued. A `print_fin` rising edge during busy is lost.
- `vals` changes after the snapshot do not affect the current pass.
- Reset (any state, including mid-CONV):
  - FSM → IDLE, `nib` = 0, `vals_q` = 0.
  - Shadow and `char_data` hex fields = 0x20, static chars as specified.
  - `busy` = 0, `upd_done` = 0, `print_fin_d` = 0.

## Timing
- `req` high at edge k in IDLE: snapshot at edge k, `busy` = 1 from edge k.
- Edges k+1..k+32: nibbles 0..31 are written to the shadow buffer.
- Edge k+33 (COMMIT): `char_data` is updated, `upd_done` = 1 for exactly the cycle after k+33, and `busy` = 0 from edge k+33.
- Request-to-commit latency is 33 cycles. Earliest next snapshot is at edge k+34 (in IDLE).
- `char_data` changes only at COMMIT edges or reset, and all 32 hex bytes change on the same edge.
- `refresh` held high continuously gives back-to-back passes every 34 cycles.
- `print_fin` edge detection needs one prior low sample. `print_fin` high at reset release is not a request until it falls and rises again.

## Test plan
- Reset:
  - Assert `rst` 2 cycles.
  - Required: `char_data` chars 0..15 = `"PC  :   "` plus 8×0x20. `busy` = 0, `upd_done` = 0.
- Single pass:
  - Drive `vals` = {0x0040_001C, 0x8C22_0004, 0xDEAD_BEEF, 0x0000_0000}, pulse `refresh` at edge k.
  - Required: `busy` high k..k+32, `upd_done` after k+33.
  - Chars 8..15 = `"0040001C"`, 24..31 = `"8C220004"`, 40..47 = `"DEADBEEF"`, 56..63 = `"00000000"`.
- Atomicity and snapshot:
  - Change `vals` to all-ones at k+5 and check `char_data` every cycle k..k+32.
  - Required: unchanged through k+32. After commit, the hex fields show the values from k, not `"FFFFFFFF"`.
- Ignored request:
  - Pulse `refresh` at k+10 with new `vals`.
  - Required: no second pass, `busy` low at k+34 with no refresh asserted.
- AUTO re-arm:
  - `AUTO` = 1, give `print_fin` 0→1 at edge m in IDLE.
  - Required: pass starts at m, `upd_done` after m+33. `print_fin` held high does not retrigger.
- Reset mid-pass:
  - Assert `rst` at k+15 after a previously committed image.
  - Required: next cycle all hex fields = 0x20, `busy` = 0, FSM IDLE, and no `upd_done` pulse.
